// File: rtl/fifo_rd_arb_pkg.sv
// Shared state type and sizing/clamping helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int lw_of(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction

  function automatic int ptr_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Zero-length requests still move one word so every grant makes progress.
  function automatic int clamp_len(input int len, input int maxburst);
    if (len == 0) return 1;
    if (len > maxburst) return maxburst;
    return len;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority picker: first requester at or above i_rr_ptr (with wrap),
// or slot 0 unconditionally when i_prio_en is set and slot 0 is requesting.
module fifo_rr_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  input  logic            i_prio_en,
  output logic [NREQ-1:0] o_win_oh,
  output logic [PW-1:0]   o_win_idx,
  output logic            o_any
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    w_idx     = '0;
    w_found   = 1'b0;
    o_win_idx = '0;
    if (i_prio_en && i_req[0]) begin
      w_found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_idx = PW'((int'(i_rr_ptr) + k) % NREQ);
        if (!w_found && i_req[w_idx]) begin
          w_found   = 1'b1;
          o_win_idx = w_idx;
        end
      end
    end
    o_win_oh = w_found ? (NREQ'(1) << o_win_idx) : '0;
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares one show-ahead async-FIFO read port among NREQ consumers, one burst per grant.
// Build option: define FIFO_RD_ARB_PRIO_EN to give consumer 0 fixed top priority.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int  DSIZE    = 8,
  parameter int  NREQ     = 4,
  parameter int  MAXBURST = 16,
  localparam int LW       = lw_of(MAXBURST)
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rempty,
  input  logic [DSIZE-1:0]   rdata,
  output logic               rinc,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]    gnt,
  output logic [DSIZE-1:0]   rd_data,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ-1:0]    burst_done
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req on every cycle
  // BURST | owner latched; pop while req[owner] && !rempty until the count expires

  localparam int PW = ptr_w(NREQ);

`ifdef FIFO_RD_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_e       r_state;
  logic [PW-1:0]    r_owner;
  logic [PW-1:0]    r_rr_ptr;
  logic [LW-1:0]    r_remaining;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rd_valid;
  logic [NREQ-1:0]  r_burst_done;
  logic [DSIZE-1:0] r_rd_data;

  logic [NREQ-1:0]  w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic             w_any;
  logic [LW-1:0]    w_lens [NREQ];
  logic [NREQ-1:0]  w_owner_oh;
  logic [PW-1:0]    w_ptr_next;
  logic [PW-1:0]    w_ptr_close;
  logic             w_req_owner;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign w_lens[g] = req_len[g*LW +: LW];
  end

  fifo_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .i_prio_en (PRIO_EN),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  assign w_req_owner = req[r_owner];
  assign w_owner_oh  = NREQ'(1) << r_owner;
  assign w_ptr_next  = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  // With fixed priority, consumer 0 bursts leave the rotation of the others untouched.
  assign w_ptr_close = (PRIO_EN && (r_owner == '0)) ? r_rr_ptr : w_ptr_next;

  assign rinc = rrst_n && (r_state == BURST) && w_req_owner && !rempty;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_remaining  <= '0;
      r_gnt        <= '0;
      r_rd_valid   <= '0;
      r_burst_done <= '0;
      r_rd_data    <= '0;
    end else begin
      r_rd_valid   <= '0;
      r_burst_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_win_idx;
            r_remaining <= LW'(clamp_len(int'(w_lens[w_win_idx]), MAXBURST));
            r_gnt       <= w_win_oh;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (!w_req_owner) begin
            r_burst_done <= w_owner_oh;
            r_gnt        <= '0;
            r_rr_ptr     <= w_ptr_close;
            r_state      <= IDLE;
          end else if (!rempty) begin
            r_rd_data   <= rdata;
            r_rd_valid  <= w_owner_oh;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LW'(1)) begin
              r_burst_done <= w_owner_oh;
              r_gnt        <= '0;
              r_rr_ptr     <= w_ptr_close;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign burst_done = r_burst_done;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: emulated show-ahead FIFO plus a transaction-level model.
module tb_fifo_rd_arbiter;

  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 16;
  localparam int LW       = 5;

  logic               rclk = 1'b0;
  logic               rrst_n = 1'b0;
  logic               rempty;
  logic [DSIZE-1:0]   rdata;
  logic               rinc;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*LW-1:0] req_len = '0;
  logic [NREQ-1:0]    gnt, rd_valid, burst_done;
  logic [DSIZE-1:0]   rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];

  logic             o_rinc;
  logic [NREQ-1:0]  o_gnt, o_vld, o_done;
  logic [DSIZE-1:0] o_data;

  fifo_rd_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .req(req), .req_len(req_len), .gnt(gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .burst_done(burst_done)
  );

  always #5 rclk = ~rclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model: arbitration and length rules ----------------
  function automatic int m_pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef FIFO_RD_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int m_len(input int l);
    return (l == 0) ? 1 : ((l > MAXBURST) ? MAXBURST : l);
  endfunction

  function automatic void m_close(input int owner);
`ifdef FIFO_RD_ARB_PRIO_EN
    if (owner == 0) return;
`endif
    m_ptr = (owner + 1) % NREQ;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fifo_sync();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_sync();
  endtask

  task automatic set_len(input int i, input logic [LW-1:0] v);
    req_len[i*LW +: LW] = v;
  endtask

  // One clock: pop the emulated FIFO if rinc was high at the edge, then sample at the falling edge.
  task automatic tick();
    logic pop;
    #2 pop = rinc;
    @(posedge rclk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    fifo_sync();
    @(negedge rclk);
    o_rinc = rinc; o_gnt = gnt; o_vld = rd_valid; o_done = burst_done; o_data = rd_data;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    req    = '0;
    tick();
    rrst_n = 1'b1;
    m_ptr  = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fifo_q.delete(); exp_q.delete(); fifo_sync();
    rrst_n = 1'b0; req = '0; req_len = '0;
    #1;
    n_checks++; if (rinc !== 1'b0) $display("FAIL reset_rinc_comb: got %b want 0", rinc); else n_pass++;
    tick(); tick();
    n_checks++; if (o_gnt !== '0) $display("FAIL reset_gnt: got %b want 0000", o_gnt); else n_pass++;
    n_checks++; if (o_vld !== '0) $display("FAIL reset_vld: got %b want 0000", o_vld); else n_pass++;
    n_checks++; if (o_done !== '0) $display("FAIL reset_done: got %b want 0000", o_done); else n_pass++;
    n_checks++; if (o_data !== '0) $display("FAIL reset_data: got %h want 00", o_data); else n_pass++;
    rrst_n = 1'b1; m_ptr = 0;
  endtask

  task automatic test_single();
    logic [DSIZE-1:0] w;
    do_reset();
    for (int i = 0; i < 4; i++) push(DSIZE'(8'h10 + i));
    set_len(2, 5'd4); req = 4'b0100;
    tick();
    n_checks++; if (o_gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", o_gnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      w = exp_q.pop_front();
      n_checks++; if (o_vld !== 4'b0100) $display("FAIL single_vld%0d: got %b want 0100", i, o_vld); else n_pass++;
      n_checks++; if (o_data !== DSIZE'(8'h10 + i) || o_data !== w) $display("FAIL single_data%0d: got %h want %h", i, o_data, DSIZE'(8'h10 + i)); else n_pass++;
      n_checks++; if (o_done !== ((i == 3) ? 4'b0100 : 4'b0000)) $display("FAIL single_done%0d: got %b", i, o_done); else n_pass++;
    end
    req = '0;
    n_checks++; if (o_gnt !== '0) $display("FAIL single_gnt_release: got %b want 0000", o_gnt); else n_pass++;
    m_close(2);
    tick();
    n_checks++; if (o_vld !== '0 || o_gnt !== '0) $display("FAIL single_quiet: vld %b gnt %b want 0", o_vld, o_gnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] oh;
    logic [DSIZE-1:0] w;
    do_reset();
    for (int i = 0; i < 12; i++) push(DSIZE'($urandom_range(0, 255)));
    for (int i = 0; i < NREQ; i++) set_len(i, 5'd2);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      oh = NREQ'(1) << (b % NREQ);
      tick();
      n_checks++; if (o_gnt !== oh) $display("FAIL rr_order%0d: gnt %b want %b", b, o_gnt, oh); else n_pass++;
      for (int k = 0; k < 2; k++) begin
        tick();
        w = exp_q.pop_front();
        n_checks++; if (o_vld !== oh || o_data !== w) $display("FAIL rr_word%0d_%0d: vld %b data %h want %b %h", b, k, o_vld, o_data, oh, w); else n_pass++;
      end
      n_checks++; if (o_done !== oh || o_gnt !== '0) $display("FAIL rr_close%0d: done %b gnt %b want %b 0000", b, o_done, o_gnt, oh); else n_pass++;
      m_close(b % NREQ);
    end
    req = '0;
    tick();
  endtask

  task automatic test_empty_stall();
    logic [DSIZE-1:0] w;
    fifo_q.delete(); exp_q.delete(); fifo_sync();
    do_reset();
    push(8'hA0);
    set_len(0, 5'd3); req = 4'b0001;
    tick();
    n_checks++; if (o_gnt !== 4'b0001) $display("FAIL stall_gnt: got %b want 0001", o_gnt); else n_pass++;
    tick();
    w = exp_q.pop_front();
    n_checks++; if (o_vld !== 4'b0001 || o_data !== w) $display("FAIL stall_first: vld %b data %h want 0001 %h", o_vld, o_data, w); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (o_rinc !== 1'b0 || o_vld !== '0 || o_gnt !== 4'b0001) $display("FAIL stall_hold%0d: rinc %b vld %b gnt %b", i, o_rinc, o_vld, o_gnt); else n_pass++;
    end
    push(8'hA1); push(8'hA2);
    for (int i = 0; i < 2; i++) begin
      tick();
      w = exp_q.pop_front();
      n_checks++; if (o_vld !== 4'b0001 || o_data !== w) $display("FAIL stall_refill%0d: vld %b data %h want 0001 %h", i, o_vld, o_data, w); else n_pass++;
      n_checks++; if (o_done !== ((i == 1) ? 4'b0001 : 4'b0000)) $display("FAIL stall_done%0d: got %b", i, o_done); else n_pass++;
    end
    req = '0; m_close(0);
    tick();
  endtask

  task automatic test_length_edges();
    int cnt, sz;
    bit closed;
    logic [DSIZE-1:0] w;
    fifo_q.delete(); exp_q.delete(); fifo_sync();
    do_reset();
    for (int i = 0; i < 3; i++) push(DSIZE'($urandom_range(0, 255)));
    // length 0 behaves as 1
    set_len(3, 5'd0); req = 4'b1000;
    tick();
    n_checks++; if (o_gnt !== 4'b1000) $display("FAIL len0_gnt: got %b want 1000", o_gnt); else n_pass++;
    tick();
    w = exp_q.pop_front();
    n_checks++; if (o_vld !== 4'b1000 || o_done !== 4'b1000 || o_data !== w) $display("FAIL len0_pop: vld %b done %b data %h want 1000 1000 %h", o_vld, o_done, o_data, w); else n_pass++;
    req = '0; m_close(3);
    tick();
    n_checks++; if (o_vld !== '0 || fifo_q.size() != 2) $display("FAIL len0_count: vld %b fifo_left %0d want 0000 2", o_vld, fifo_q.size()); else n_pass++;
    // length 31 clamps to MAXBURST
    for (int i = 0; i < 20; i++) push(DSIZE'($urandom_range(0, 255)));
    set_len(2, 5'd31); req = 4'b0100;
    tick();
    cnt = 0; closed = 0;
    for (int c = 0; c < 40 && !closed; c++) begin
      tick();
      if (o_vld !== '0) begin
        cnt++;
        w = exp_q.pop_front();
        n_checks++; if (o_vld !== 4'b0100 || o_data !== w) $display("FAIL len31_word%0d: vld %b data %h want 0100 %h", cnt, o_vld, o_data, w); else n_pass++;
      end
      if (o_done !== '0) closed = 1;
    end
    n_checks++; if (!closed || cnt != MAXBURST) $display("FAIL len31_clamp: closed %0d pops %0d want 1 %0d", closed, cnt, MAXBURST); else n_pass++;
    req = '0; m_close(2);
    // abort after two pops
    for (int i = 0; i < 4; i++) push(DSIZE'($urandom_range(0, 255)));
    sz = fifo_q.size();
    set_len(1, 5'd8); req = 4'b0010;
    tick();
    n_checks++; if (o_gnt !== 4'b0010) $display("FAIL abort_gnt: got %b want 0010", o_gnt); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      w = exp_q.pop_front();
      n_checks++; if (o_vld !== 4'b0010 || o_data !== w) $display("FAIL abort_word%0d: vld %b data %h want 0010 %h", i, o_vld, o_data, w); else n_pass++;
    end
    req = '0;
    #1;
    n_checks++; if (rinc !== 1'b0) $display("FAIL abort_rinc: got %b want 0", rinc); else n_pass++;
    tick();
    n_checks++; if (o_done !== 4'b0010 || o_vld !== '0 || o_gnt !== '0) $display("FAIL abort_close: done %b vld %b gnt %b want 0010 0000 0000", o_done, o_vld, o_gnt); else n_pass++;
    m_close(1);
    tick();
    n_checks++; if (o_vld !== '0 || o_done !== '0 || fifo_q.size() != sz - 2) $display("FAIL abort_after: vld %b done %b popped %0d want 0 0 2", o_vld, o_done, sz - fifo_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [DSIZE-1:0] w;
    do_reset();
    for (int i = 0; i < 10; i++) push(DSIZE'($urandom_range(0, 255)));
    set_len(2, 5'd8); req = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      w = exp_q.pop_front();
      n_checks++; if (o_vld !== 4'b0100 || o_data !== w) $display("FAIL rstmid_word%0d: vld %b data %h want 0100 %h", i, o_vld, o_data, w); else n_pass++;
    end
    rrst_n = 1'b0;
    #1;
    n_checks++; if (rinc !== 1'b0) $display("FAIL rstmid_rinc: got %b want 0", rinc); else n_pass++;
    tick();
    n_checks++; if (o_gnt !== '0 || o_done !== '0 || o_vld !== '0) $display("FAIL rstmid_clear: gnt %b done %b vld %b want 0", o_gnt, o_done, o_vld); else n_pass++;
    rrst_n = 1'b1; m_ptr = 0; req = 4'b1111;
    tick();
    n_checks++; if (o_gnt !== 4'b0001 || o_done !== '0) $display("FAIL rstmid_ptr: gnt %b done %b want 0001 0000", o_gnt, o_done); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (o_done !== 4'b0001 || o_vld !== '0) $display("FAIL rstmid_abort: done %b vld %b want 0001 0000", o_done, o_vld); else n_pass++;
    m_close(0);
  endtask

  task automatic test_prio();
    int exp_o, first_c;
    logic [DSIZE-1:0] w;
    do_reset();
    for (int i = 0; i < 8; i++) push(DSIZE'($urandom_range(0, 255)));
    for (int i = 0; i < NREQ; i++) set_len(i, 5'd1);
    req = 4'b0001;
    tick(); tick();
    w = exp_q.pop_front();
    req = 4'b0011; m_close(0);
`ifdef FIFO_RD_ARB_PRIO_EN
    first_c = 0;
`else
    first_c = 1;
`endif
    for (int b = 0; b < 3; b++) begin
      exp_o = m_pick(req, m_ptr);
      tick();
      n_checks++; if (o_gnt !== (NREQ'(1) << exp_o) || (b == 0 && exp_o != first_c)) $display("FAIL prio_gnt%0d: gnt %b want owner %0d", b, o_gnt, exp_o); else n_pass++;
      tick();
      w = exp_q.pop_front();
      n_checks++; if (o_done !== (NREQ'(1) << exp_o) || o_data !== w) $display("FAIL prio_word%0d: done %b data %h want owner %0d %h", b, o_done, o_data, exp_o, w); else n_pass++;
      m_close(exp_o);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r, oh;
    logic [DSIZE-1:0] w;
    int owner, elen, cnt;
    bit closed;
    do_reset();
    for (int b = 0; b < 20; b++) begin
      r = NREQ'($urandom_range(1, 15));
      req = r;
      for (int i = 0; i < NREQ; i++) set_len(i, LW'($urandom_range(0, 31)));
      owner = m_pick(r, m_ptr);
      elen  = m_len(int'(req_len[owner*LW +: LW]));
      oh    = NREQ'(1) << owner;
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) push(DSIZE'($urandom_range(0, 255)));
      tick();
      n_checks++; if (o_gnt !== oh) $display("FAIL rand_gnt%0d: got %b want %b", b, o_gnt, oh); else n_pass++;
      cnt = 0; closed = 0;
      for (int c = 0; c < 300 && !closed; c++) begin
        r = NREQ'($urandom_range(0, 15));
        r[owner] = 1'b1;
        req = r;
        for (int i = 0; i < NREQ; i++) if (i != owner) set_len(i, LW'($urandom_range(0, 31)));
        if ($urandom_range(0, 2) == 0) push(DSIZE'($urandom_range(0, 255)));
        tick();
        if (o_vld !== '0) begin
          cnt++;
          w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          n_checks++; if (o_vld !== oh || o_data !== w) $display("FAIL rand_word%0d_%0d: vld %b data %h want %b %h", b, cnt, o_vld, o_data, oh, w); else n_pass++;
        end
        if (o_done !== '0) begin
          closed = 1;
          n_checks++; if (o_done !== oh || o_gnt !== '0 || cnt != elen) $display("FAIL rand_close%0d: done %b gnt %b pops %0d want %b 0000 %0d", b, o_done, o_gnt, cnt, oh, elen); else n_pass++;
        end
      end
      if (!closed) begin
        n_checks++;
        $display("FAIL rand_timeout%0d: burst for owner %0d never closed", b, owner);
      end
      m_close(owner);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_empty_stall();
    test_length_edges();
    test_reset_mid_burst();
    test_prio();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
